// File: rtl/instruction_prefetcher.sv
// Instruction prefetcher: fetches 16-bit words at CS:IP and splits them into bytes.
// The bytes go into a small FIFO that the decode stage pops one at a time.
module instruction_prefetcher #(
    parameter int          FIFO_DEPTH = 6,
    parameter logic [15:0] RESET_CS   = 16'hFFFF,
    parameter logic [15:0] RESET_IP   = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_new_ip,
    input  logic [15:0] new_cs,
    input  logic [15:0] new_ip,
    output logic        mem_access,
    input  logic        mem_ack,
    output logic [18:0] mem_address,
    input  logic [15:0] mem_data,
    input  logic        fifo_rd_en,
    output logic [7:0]  fifo_rd_data,
    output logic        fifo_empty
);

    localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DISCARD
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     cs_q, cs_d;
    logic [15:0]     ip_q, ip_d;
    logic [18:0]     addr_q, addr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [1:0]      push_n;
    logic            pop;
    logic [19:0]     phys;

    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
        logic [PW+1:0] s;
        s = {2'b00, p} + {{PW{1'b0}}, n};
        if (s >= (PW+2)'(FIFO_DEPTH))
            s = s - (PW+2)'(FIFO_DEPTH);
        return s[PW-1:0];
    endfunction

    assign phys = {cs_q, 4'b0000} + {4'b0000, ip_q};

    always_comb begin
        state_d  = state_q;
        cs_d     = cs_q;
        ip_d     = ip_q;
        addr_d   = addr_q;
        push_n   = 2'd0;
        pop      = fifo_rd_en && (count_q != '0);

        case (state_q)
            S_IDLE: begin
                if (!load_new_ip && (count_q <= CW'(FIFO_DEPTH - 2))) begin
                    state_d = S_FETCH;
                    addr_d  = phys[19:1];
                end
            end
            S_FETCH: begin
                if (load_new_ip) begin
                    state_d = mem_ack ? S_IDLE : S_DISCARD;
                end else if (mem_ack) begin
                    state_d = S_IDLE;
                    // An odd IP only wants the high byte of the word.
                    if (phys[0]) begin
                        push_n = 2'd1;
                        ip_d   = ip_q + 16'd1;
                    end else begin
                        push_n = 2'd2;
                        ip_d   = ip_q + 16'd2;
                    end
                end
            end
            S_DISCARD: begin
                if (mem_ack)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (load_new_ip) begin
            cs_d     = new_cs;
            ip_d     = new_ip;
            push_n   = 2'd0;
            pop      = 1'b0;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            count_d  = count_q + CW'(push_n) - CW'(pop);
            rd_ptr_d = ptr_add(rd_ptr_q, {1'b0, pop});
            wr_ptr_d = ptr_add(wr_ptr_q, push_n);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cs_q     <= RESET_CS;
            ip_q     <= RESET_IP;
            addr_q   <= '0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            cs_q     <= cs_d;
            ip_q     <= ip_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_n == 2'd2) begin
            fifo_mem[wr_ptr_q]                <= mem_data[7:0];
            fifo_mem[ptr_add(wr_ptr_q, 2'd1)] <= mem_data[15:8];
        end else if (push_n == 2'd1) begin
            fifo_mem[wr_ptr_q] <= mem_data[15:8];
        end
    end

    assign mem_access   = (state_q != S_IDLE);
    assign mem_address  = addr_q;
    assign fifo_empty   = (count_q == '0);
    assign fifo_rd_data = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q];

endmodule
